// File: rtl/icache_way_encode_pkg.sv
// -----------------------------------------------------------------------------
// icache_way_encode_pkg
// Shared icache way-path definitions: way count, way-index type, the packed
// way-entry struct {idx, hit, multi}, and the stored entry width helper used
// by the way encoder pipeline.
//
// Configuration macro: ICACHE_WAY_ENC_MULTI_CHK_EN
//   defined   -> each stored entry carries a multi-hit bit
//   undefined -> entries carry only {hit, idx}
// -----------------------------------------------------------------------------
package icache_way_encode_pkg;

    // Number of ways in the icache.
    localparam int WAYS   = 8;
    localparam int WAY_IW = $clog2(WAYS);

    // Binary way index.
    typedef logic [$clog2(WAYS)-1:0] way_idx_t;

    // One encoded way vector.
    typedef struct packed {
        way_idx_t idx;
        logic     hit;
        logic     multi;
    } way_ent_t;

`ifdef ICACHE_WAY_ENC_MULTI_CHK_EN
    localparam int ENT_MULTI_W = 1;
`else
    localparam int ENT_MULTI_W = 0;
`endif

    // Stored entry width for an index width iw: idx + hit (+ multi if enabled).
    function automatic int ent_width(input int iw);
        return iw + 1 + ENT_MULTI_W;
    endfunction

endpackage

// File: rtl/icache_way_encode_v_en_encode1.sv
// -----------------------------------------------------------------------------
// v_en_encode1
// Combinational one-hot/hit-vector to binary encoder; the mirror of the icache
// one-hot enable decoder. Reusable for the way, LRU and refill select paths.
//
// Parameters:
//   WIDTH  vector width (>= 2); IW = $clog2(WIDTH)
// Ports:
//   vec    in   WIDTH  per-way hit/enable vector
//   idx    out  IW     index of the lowest set bit (0 when vec is all zero)
//   hit    out  1      vec has at least one bit set
//   multi  out  1      vec has two or more bits set (0 when the check is off)
//
// Configuration macro: ICACHE_WAY_ENC_MULTI_CHK_EN enables the multi output;
// otherwise multi is tied to 0 and no detection logic exists.
// -----------------------------------------------------------------------------
module v_en_encode1
    import icache_way_encode_pkg::*;
#(
    parameter  int WIDTH = WAYS,
    localparam int IW    = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] vec,
    output logic [IW-1:0]    idx,
    output logic             hit,
    output logic             multi
);

    logic [IW-1:0] idx_s;

    // Priority encode: scan from the top so the lowest set bit wins last.
    always_comb begin
        idx_s = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx_s = IW'(i);
            end else begin
                idx_s = idx_s;
            end
        end
    end

    assign idx = idx_s;
    assign hit = |vec;

`ifdef ICACHE_WAY_ENC_MULTI_CHK_EN
    // Clearing the lowest set bit leaves something only if 2+ bits were set.
    assign multi = |(vec & (vec - WIDTH'(1)));
`else
    assign multi = 1'b0;
`endif

endmodule

// File: rtl/icache_way_encode.sv
// -----------------------------------------------------------------------------
// icache_way_encode
// Pipelined one-hot-to-index encoder for the icache way path. Converts a
// per-way hit/enable vector into {index, hit, multi} and holds it in a main
// output register M backed by a one-entry skid register S, giving a 2-deep
// strictly ordered valid/ready pipeline with registered outputs.
//
// Parameters:
//   WIDTH      number of ways (>= 2); IW = $clog2(WIDTH)
// Ports:
//   clk        in   1      clock
//   rst        in   1      synchronous active-high reset
//   in_vld     in   1      input vector valid
//   in_rdy     out  1      can accept (registered, = !S valid)
//   in_vec     in   WIDTH  per-way hit/enable vector
//   out_vld    out  1      M holds a valid entry
//   out_rdy    in   1      consumer accepts output
//   out_index  out  IW     index of lowest set bit
//   out_hit    out  1      vector had >= 1 bit set
//   out_multi  out  1      vector had >= 2 bits set (0 without the macro)
//   err_sticky out  1      latched multi-hit error (0 without the macro)
//   err_clr    in   1      clears err_sticky (ignored without the macro)
//
// Configuration macro: ICACHE_WAY_ENC_MULTI_CHK_EN
//   defined   -> multi-hit detection stored per entry, err_sticky/err_clr
//                active, checker flags any valid multi-hit output
//   undefined -> no detection logic or storage; out_multi/err_sticky tied 0
// -----------------------------------------------------------------------------
module icache_way_encode
    import icache_way_encode_pkg::*;
#(
    parameter  int WIDTH = WAYS,
    localparam int IW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [WIDTH-1:0] in_vec,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [IW-1:0]    out_index,
    output logic             out_hit,
    output logic             out_multi,
    output logic             err_sticky,
    input  logic             err_clr
);

    // Stored entry layout: [IW+1] multi (if enabled), [IW] hit, [IW-1:0] idx.
    localparam int EW = ent_width(IW);

    logic [IW-1:0] enc_idx_s;
    logic          enc_hit_s;
    logic          enc_multi_s;
    logic [EW-1:0] enc_ent_s;

    logic          m_vld_r;
    logic [EW-1:0] m_ent_r;
    logic          s_vld_r;
    logic [EW-1:0] s_ent_r;
    logic          in_rdy_r;

    logic          m_vld_nx_s;
    logic [EW-1:0] m_ent_nx_s;
    logic          s_vld_nx_s;
    logic [EW-1:0] s_ent_nx_s;
    logic          m_load_s;

    logic          accept_s;
    logic          pop_s;
    logic          m_free_s;

    v_en_encode1 #(
        .WIDTH (WIDTH)
    ) u_enc (
        .vec   (in_vec),
        .idx   (enc_idx_s),
        .hit   (enc_hit_s),
        .multi (enc_multi_s)
    );

`ifdef ICACHE_WAY_ENC_MULTI_CHK_EN
    assign enc_ent_s = {enc_multi_s, enc_hit_s, enc_idx_s};
`else
    assign enc_ent_s = {enc_hit_s, enc_idx_s};
`endif

    assign accept_s = in_vld && in_rdy_r;
    assign pop_s    = m_vld_r && out_rdy;
    // M can take a new entry this edge if it is empty or being drained.
    assign m_free_s = !m_vld_r || pop_s;

    // Next-state for M and S: S has priority into M to keep FIFO order.
    always_comb begin
        m_vld_nx_s = m_vld_r;
        m_ent_nx_s = m_ent_r;
        s_vld_nx_s = s_vld_r;
        s_ent_nx_s = s_ent_r;
        m_load_s   = 1'b0;
        if (m_free_s) begin
            if (s_vld_r) begin
                m_vld_nx_s = 1'b1;
                m_ent_nx_s = s_ent_r;
                m_load_s   = 1'b1;
                if (accept_s) begin
                    s_vld_nx_s = 1'b1;
                    s_ent_nx_s = enc_ent_s;
                end else begin
                    s_vld_nx_s = 1'b0;
                end
            end else if (accept_s) begin
                m_vld_nx_s = 1'b1;
                m_ent_nx_s = enc_ent_s;
                m_load_s   = 1'b1;
            end else begin
                m_vld_nx_s = 1'b0;
            end
        end else begin
            // M is held under back-pressure; its contents must not change.
            if (accept_s) begin
                s_vld_nx_s = 1'b1;
                s_ent_nx_s = enc_ent_s;
            end else begin
                s_vld_nx_s = s_vld_r;
            end
        end
    end

    // Pipeline state registers; in_rdy is registered from the next S state.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_vld_r  <= 1'b0;
            m_ent_r  <= '0;
            s_vld_r  <= 1'b0;
            s_ent_r  <= '0;
            in_rdy_r <= 1'b1;
        end else begin
            m_vld_r  <= m_vld_nx_s;
            m_ent_r  <= m_ent_nx_s;
            s_vld_r  <= s_vld_nx_s;
            s_ent_r  <= s_ent_nx_s;
            in_rdy_r <= !s_vld_nx_s;
        end
    end

    assign in_rdy    = in_rdy_r;
    assign out_vld   = m_vld_r;
    assign out_index = m_ent_r[IW-1:0];
    assign out_hit   = m_ent_r[IW];

`ifdef ICACHE_WAY_ENC_MULTI_CHK_EN
    logic err_sticky_r;

    // Sticky multi-hit flag: a multi-hit entry entering M beats a clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_sticky_r <= 1'b0;
        end else if (m_load_s && m_ent_nx_s[IW+1]) begin
            err_sticky_r <= 1'b1;
        end else if (err_clr) begin
            err_sticky_r <= 1'b0;
        end else begin
            err_sticky_r <= err_sticky_r;
        end
    end

    assign out_multi  = m_ent_r[IW+1];
    assign err_sticky = err_sticky_r;

    icache_way_encode_chk u_chk (
        .clk       (clk),
        .rst       (rst),
        .out_vld   (out_vld),
        .out_multi (out_multi)
    );
`else
    // Detection is compiled out; these inputs are intentionally unused.
    logic unused_s;
    assign unused_s   = ^{err_clr, enc_multi_s};
    assign out_multi  = 1'b0;
    assign err_sticky = 1'b0;
`endif

endmodule

`ifdef ICACHE_WAY_ENC_MULTI_CHK_EN
// -----------------------------------------------------------------------------
// icache_way_encode_chk
// Simulation checker: flags any valid output entry that carries a multi-hit.
// Ports: clk, rst, out_vld, out_multi (all inputs).
// -----------------------------------------------------------------------------
module icache_way_encode_chk (
    input logic clk,
    input logic rst,
    input logic out_vld,
    input logic out_multi
);

    // Multi-hit on a presented entry indicates a tag-compare fault upstream.
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(out_vld && out_multi))
                else $error("icache_way_encode: multi-hit way vector presented");
        end
    end

endmodule
`endif

// File: tb/tb_icache_way_encode.sv
// -----------------------------------------------------------------------------
// tb_icache_way_encode
// Directed testbench for icache_way_encode with a scoreboard queue of expected
// entries. Honors ICACHE_WAY_ENC_MULTI_CHK_EN for the expected multi/err values.
// -----------------------------------------------------------------------------
module tb_icache_way_encode;
    import icache_way_encode_pkg::*;

    logic       clk;
    logic       rst;
    logic       in_vld;
    logic       in_rdy;
    logic [7:0] in_vec;
    logic       out_vld;
    logic       out_rdy;
    logic [2:0] out_index;
    logic       out_hit;
    logic       out_multi;
    logic       err_sticky;
    logic       err_clr;

    int         errors = 0;
    int         checks = 0;
    int         cnt    = 0;
    int         pops   = 0;
    logic       err_exp = 1'b0;
    way_ent_t   sb[$];

    icache_way_encode #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_vld     (in_vld),
        .in_rdy     (in_rdy),
        .in_vec     (in_vec),
        .out_vld    (out_vld),
        .out_rdy    (out_rdy),
        .out_index  (out_index),
        .out_hit    (out_hit),
        .out_multi  (out_multi),
        .err_sticky (err_sticky),
        .err_clr    (err_clr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference encoding: scan upward, first set bit wins.
    function automatic way_ent_t model_enc(input logic [7:0] v);
        way_ent_t e;
        e.idx   = 3'd0;
        e.hit   = 1'b0;
        e.multi = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (v[i] && !e.hit) begin
                e.idx = 3'(i);
                e.hit = 1'b1;
            end
        end
`ifdef ICACHE_WAY_ENC_MULTI_CHK_EN
        e.multi = ($countones(v) > 1);
`endif
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
            else begin
                errors++;
                $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
            end
    endtask

    // One cycle: drive at negedge, check current outputs, update model, clock.
    task automatic step(input logic v, input logic [7:0] vec, input logic rdy, input logic clr);
        logic acc;
        logic pop;
        logic mfree;
        in_vld  = v;
        in_vec  = vec;
        out_rdy = rdy;
        err_clr = clr;
        #1;
        chk("out_vld", 32'(out_vld), 32'(cnt > 0));
        chk("in_rdy", 32'(in_rdy), 32'(cnt < 2));
        chk("err_sticky", 32'(err_sticky), 32'(err_exp));
        if (cnt > 0) begin
            chk("out_index", 32'(out_index), 32'(sb[0].idx));
            chk("out_hit", 32'(out_hit), 32'(sb[0].hit));
            chk("out_multi", 32'(out_multi), 32'(sb[0].multi));
        end
        pop   = (cnt > 0) && rdy;
        acc   = v && (cnt < 2);
        mfree = (cnt == 0) || pop;
        if (pop) begin
            void'(sb.pop_front());
            pops++;
        end
        if (acc) begin
            sb.push_back(model_enc(vec));
        end
        cnt = sb.size();
        if (mfree && (cnt > 0) && sb[0].multi) begin
            err_exp = 1'b1;
        end else if (clr) begin
            err_exp = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        in_vld  = 1'b0;
        in_vec  = 8'h00;
        out_rdy = 1'b0;
        err_clr = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        cnt     = 0;
        err_exp = 1'b0;
        #1;
        chk("rst_out_vld", 32'(out_vld), 32'd0);
        chk("rst_in_rdy", 32'(in_rdy), 32'd1);
        chk("rst_out_index", 32'(out_index), 32'd0);
        chk("rst_out_hit", 32'(out_hit), 32'd0);
        chk("rst_out_multi", 32'(out_multi), 32'd0);
        chk("rst_err_sticky", 32'(err_sticky), 32'd0);
    endtask

    initial begin
        int p0;
        do_reset();

        // Basic encodes: bit 4, zero vector, top bit.
        step(1'b1, 8'b0001_0000, 1'b1, 1'b0);
        step(1'b1, 8'b0000_0000, 1'b1, 1'b0);
        step(1'b1, 8'b1000_0000, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // Multi-hit vector, sticky error, clear, and clear colliding with a set.
        step(1'b1, 8'b0010_0100, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b1, 8'b0010_0100, 1'b1, 1'b0);
        step(1'b1, 8'b0000_0011, 1'b1, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // Streaming 01,02,04,08 with a 3-cycle stall; fills M and S.
        step(1'b1, 8'h01, 1'b0, 1'b0);
        step(1'b1, 8'h02, 1'b0, 1'b0);
        step(1'b1, 8'h04, 1'b0, 1'b0);
        chk("full_in_rdy", 32'(in_rdy), 32'd0);
        step(1'b1, 8'h04, 1'b1, 1'b0);
        step(1'b1, 8'h04, 1'b1, 1'b0);
        step(1'b1, 8'h08, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // Full throughput: 16 vectors in, 16 out.
        p0 = pops;
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 8'($urandom_range(0, 255)), 1'b1, 1'b0);
        end
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("thru_pops", 32'(pops - p0), 32'd16);

        // Random handshake mix.
        for (int i = 0; i < 40; i++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
        end

        // Reset while M and S are both full.
        step(1'b1, 8'h40, 1'b0, 1'b0);
        step(1'b1, 8'h20, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        do_reset();
        step(1'b0, 8'h00, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
